gen3_multilane_scrambler: RTL

//  Parametrised 128b/130b transmit scrambler for NUM_LANES lanes, each carrying up to BYTES_PER_LANE

---
 rtl/gen3_multilane_scrambler.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/gen3_multilane_scrambler.sv
// 128b/130b transmit scrambler for NUM_LANES lanes with a runtime PIPE width (8/16/32 bits per lane).
// Each lane tracks its symbol index and block type so ordered sets bypass, hold or reseed the LFSR.
module gen3_multilane_scrambler #(
    parameter int unsigned NUM_LANES      = 4,
    parameter int unsigned BYTES_PER_LANE = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [8*NUM_LANES-1:0]                lane_num_i,
    input  logic [5:0]                            pipe_width_i,
    input  logic                                  data_valid_i,
    input  logic                                  block_start_i,
    input  logic [1:0]                            sync_header_i,
    input  logic [NUM_LANES-1:0]                  dc_bal_bypass_i,
    input  logic [8*BYTES_PER_LANE*NUM_LANES-1:0] data_in_i,
    output logic                                  data_valid_o,
    output logic                                  block_start_o,
    output logic [1:0]                            sync_header_o,
    output logic [8*BYTES_PER_LANE*NUM_LANES-1:0] data_out_o,
    output logic                                  align_err_o
);

    localparam int unsigned DW = 8*BYTES_PER_LANE*NUM_LANES;

    typedef enum logic [2:0] {BlkData, BlkEieos, BlkSkp, BlkTs, BlkOs} blk_type_e;

    function automatic logic [22:0] seed_of(input logic [2:0] idx);
        logic [22:0] s;
        case (idx)
            3'd0:    s = 23'h1DBFBC;
            3'd1:    s = 23'h0607BB;
            3'd2:    s = 23'h1EC760;
            3'd3:    s = 23'h18C0DB;
            3'd4:    s = 23'h010F12;
            3'd5:    s = 23'h19CFC9;
            3'd6:    s = 23'h0277CE;
            default: s = 23'h1BB807;
        endcase
        return s;
    endfunction

    function automatic blk_type_e classify(input logic [1:0] sh, input logic [7:0] sym0);
        blk_type_e t;
        if (sh != 2'b10) begin
            t = BlkData;
        end else begin
            case (sym0)
                8'h00:        t = BlkEieos;
                8'hAA:        t = BlkSkp;
                8'h1E, 8'h2D: t = BlkTs;
                default:      t = BlkOs;
            endcase
        end
        return t;
    endfunction

    // Eight serial Galois advances; returns {scramble byte (LSB = first bit), next state}.
    function automatic logic [30:0] lfsr_byte(input logic [22:0] s);
        logic [22:0] st;
        logic [7:0]  key;
        st = s;
        for (int i = 0; i < 8; i++) begin
            key[i] = st[22];
            st     = {st[21:0], 1'b0} ^ (st[22] ? 23'h210125 : 23'h000000);
        end
        return {key, st};
    endfunction

    logic [22:0]          r_lfsr [NUM_LANES];
    logic [3:0]           r_cnt  [NUM_LANES];
    blk_type_e            r_type [NUM_LANES];
    logic [NUM_LANES-1:0] r_dcb;

    logic [22:0]          w_seed [NUM_LANES];
    logic [22:0]          w_lfsr [NUM_LANES];
    logic [3:0]           w_cnt  [NUM_LANES];
    blk_type_e            w_type [NUM_LANES];
    logic [NUM_LANES-1:0] w_dcb;
    logic [DW-1:0]        w_data_out;
    logic                 w_align_err;
    logic [4:0]           w_n;
    logic                 w_unused;

    assign w_unused = ^{lane_num_i, pipe_width_i[2:0]};

    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            w_seed[l] = seed_of(lane_num_i[l*8 +: 3]);
        end
    end

    always_comb begin
        logic [22:0] w_l_lfsr;
        logic [3:0]  w_l_cnt;
        blk_type_e   w_l_type;
        logic        w_l_dcb;
        logic [30:0] w_step;
        logic [7:0]  w_sym;
        logic        w_byp;

        w_n = {2'b00, pipe_width_i[5:3]};
        if (w_n > 5'(BYTES_PER_LANE)) begin
            w_n = 5'(BYTES_PER_LANE);
        end

        w_align_err = 1'b0;
        w_data_out  = '0;
        w_dcb       = r_dcb;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (r_cnt[l] != 4'd0) begin
                w_align_err = w_align_err | (block_start_i & data_valid_i);
            end

            w_l_lfsr = r_lfsr[l];
            w_l_cnt  = r_cnt[l];
            w_l_type = r_type[l];
            w_l_dcb  = r_dcb[l];
            w_step   = '0;
            w_sym    = '0;
            w_byp    = 1'b0;

            // A pending EIEOS reseed is applied before the new block is taken.
            if (data_valid_i && block_start_i) begin
                if (w_l_type == BlkEieos) begin
                    w_l_lfsr = w_seed[l];
                end
                w_l_cnt  = 4'd0;
                w_l_type = classify(sync_header_i, data_in_i[l*BYTES_PER_LANE*8 +: 8]);
                w_l_dcb  = dc_bal_bypass_i[l];
            end

            for (int b = 0; b < BYTES_PER_LANE; b++) begin
                if (5'(b) < w_n) begin
                    w_step = lfsr_byte(w_l_lfsr);
                    w_sym  = data_in_i[(l*BYTES_PER_LANE+b)*8 +: 8];
                    case (w_l_type)
                        BlkData: w_byp = 1'b0;
                        BlkTs:   w_byp = (w_l_cnt == 4'd0) || ((w_l_cnt >= 4'd14) && w_l_dcb);
                        default: w_byp = 1'b1;
                    endcase
                    w_data_out[(l*BYTES_PER_LANE+b)*8 +: 8] = w_byp ? w_sym
                                                                     : (w_sym ^ w_step[30:23]);
                    if (w_l_type != BlkSkp) begin
                        w_l_lfsr = w_step[22:0];
                    end
                    if ((w_l_type == BlkEieos) && (w_l_cnt == 4'd15)) begin
                        w_l_lfsr = w_seed[l];
                    end
                    w_l_cnt = w_l_cnt + 4'd1;
                end
            end

            w_lfsr[l] = w_l_lfsr;
            w_cnt[l]  = w_l_cnt;
            w_type[l] = w_l_type;
            w_dcb[l]  = w_l_dcb;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                r_lfsr[l] <= w_seed[l];
                r_cnt[l]  <= 4'd0;
                r_type[l] <= BlkData;
            end
            r_dcb         <= '0;
            data_valid_o  <= 1'b0;
            block_start_o <= 1'b0;
            sync_header_o <= 2'b00;
            data_out_o    <= '0;
            align_err_o   <= 1'b0;
        end else begin
            data_valid_o  <= data_valid_i;
            block_start_o <= block_start_i;
            sync_header_o <= sync_header_i;
            align_err_o   <= w_align_err;
            if (data_valid_i) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    r_lfsr[l] <= w_lfsr[l];
                    r_cnt[l]  <= w_cnt[l];
                    r_type[l] <= w_type[l];
                end
                r_dcb      <= w_dcb;
                data_out_o <= w_data_out;
            end
        end
    end

endmodule
